// File: rtl/plugin_collector.sv
// Collects one round of plugin results: start pulse, fixed collect window,
// snapshot of all plugin buses, then a serial per-plugin sum handed off on valid/ready.
module plugin_collector #(
    parameter int NUM_PLUGINS    = 3,
    parameter int WARP_WIDTH     = 16,
    parameter int ERROR_WIDTH    = 32,
    parameter int ACC_WIDTH      = 20,
    parameter int COLLECT_CYCLES = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req,
    output logic                               busy,
    output logic                               plugin_start,
    input  logic [NUM_PLUGINS-1:0]             plugin_valid_bus,
    input  logic [NUM_PLUGINS*WARP_WIDTH-1:0]  plugin_warp_x_bus,
    input  logic [NUM_PLUGINS*WARP_WIDTH-1:0]  plugin_warp_y_bus,
    input  logic [NUM_PLUGINS*WARP_WIDTH-1:0]  plugin_warp_z_bus,
    input  logic [NUM_PLUGINS*ERROR_WIDTH-1:0] plugin_error_bus,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [ACC_WIDTH-1:0]               acc_x,
    output logic [ACC_WIDTH-1:0]               acc_y,
    output logic [ACC_WIDTH-1:0]               acc_z,
    output logic [ERROR_WIDTH-1:0]             acc_error,
    output logic                               err_sat,
    output logic [NUM_PLUGINS-1:0]             missing_mask
);

    localparam int CNT_W = (COLLECT_CYCLES > 1) ? $clog2(COLLECT_CYCLES) : 1;
    localparam int IDX_W = (NUM_PLUGINS > 1) ? $clog2(NUM_PLUGINS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COLLECT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLUGINS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_COLLECT,
        S_SUM,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [NUM_PLUGINS-1:0]             snap_valid_q, snap_valid_d;
    logic [NUM_PLUGINS*WARP_WIDTH-1:0]  snap_x_q, snap_x_d;
    logic [NUM_PLUGINS*WARP_WIDTH-1:0]  snap_y_q, snap_y_d;
    logic [NUM_PLUGINS*WARP_WIDTH-1:0]  snap_z_q, snap_z_d;
    logic [NUM_PLUGINS*ERROR_WIDTH-1:0] snap_err_q, snap_err_d;

    logic signed [ACC_WIDTH-1:0] acc_x_q, acc_x_d;
    logic signed [ACC_WIDTH-1:0] acc_y_q, acc_y_d;
    logic signed [ACC_WIDTH-1:0] acc_z_q, acc_z_d;
    logic [ERROR_WIDTH-1:0]      acc_error_q, acc_error_d;
    logic                        err_sat_q, err_sat_d;
    logic [NUM_PLUGINS-1:0]      missing_mask_q, missing_mask_d;

    logic busy_q, busy_d;
    logic plugin_start_q, plugin_start_d;
    logic out_valid_q, out_valid_d;

    logic snap_now;
    logic sum_last;

    function automatic logic signed [ACC_WIDTH-1:0] sext_warp(input logic signed [WARP_WIDTH-1:0] v);
        return ACC_WIDTH'(v);
    endfunction

    // Returns {saturated, sum}; once saturated the sum stays clamped at all-ones.
    function automatic logic [ERROR_WIDTH:0] sat_add(input logic [ERROR_WIDTH-1:0] a,
                                                     input logic [ERROR_WIDTH-1:0] b,
                                                     input logic                   sat_in);
        logic [ERROR_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[ERROR_WIDTH] || sat_in) begin
            return {1'b1, {ERROR_WIDTH{1'b1}}};
        end
        return s;
    endfunction

    assign snap_now = (state_q == S_COLLECT) && (cnt_q == LAST_CNT);
    assign sum_last = (state_q == S_SUM) && (idx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (req) state_d = S_START;
            S_START:   state_d = S_COLLECT;
            S_COLLECT: if (snap_now) state_d = S_SUM;
            S_SUM:     if (sum_last) state_d = S_DONE;
            S_DONE:    if (out_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Control outputs are registered, so they are decoded from the next state.
    always_comb begin
        busy_d         = (state_d != S_IDLE);
        plugin_start_d = (state_d == S_START);
        out_valid_d    = (state_d == S_DONE);
    end

    always_comb begin
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        snap_valid_d   = snap_valid_q;
        snap_x_d       = snap_x_q;
        snap_y_d       = snap_y_q;
        snap_z_d       = snap_z_q;
        snap_err_d     = snap_err_q;
        acc_x_d        = acc_x_q;
        acc_y_d        = acc_y_q;
        acc_z_d        = acc_z_q;
        acc_error_d    = acc_error_q;
        err_sat_d      = err_sat_q;
        missing_mask_d = missing_mask_q;

        case (state_q)
            S_START: cnt_d = '0;
            S_COLLECT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (snap_now) begin
                    snap_valid_d   = plugin_valid_bus;
                    snap_x_d       = plugin_warp_x_bus;
                    snap_y_d       = plugin_warp_y_bus;
                    snap_z_d       = plugin_warp_z_bus;
                    snap_err_d     = plugin_error_bus;
                    acc_x_d        = '0;
                    acc_y_d        = '0;
                    acc_z_d        = '0;
                    acc_error_d    = '0;
                    err_sat_d      = 1'b0;
                    missing_mask_d = '0;
                    idx_d          = '0;
                end
            end
            S_SUM: begin
                idx_d = idx_q + IDX_W'(1);
                for (int i = 0; i < NUM_PLUGINS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        if (snap_valid_q[i]) begin
                            acc_x_d = acc_x_q + sext_warp(snap_x_q[i*WARP_WIDTH +: WARP_WIDTH]);
                            acc_y_d = acc_y_q + sext_warp(snap_y_q[i*WARP_WIDTH +: WARP_WIDTH]);
                            acc_z_d = acc_z_q + sext_warp(snap_z_q[i*WARP_WIDTH +: WARP_WIDTH]);
                            {err_sat_d, acc_error_d} = sat_add(acc_error_q,
                                snap_err_q[i*ERROR_WIDTH +: ERROR_WIDTH], err_sat_q);
                        end else begin
                            missing_mask_d[i] = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            idx_q          <= '0;
            snap_valid_q   <= '0;
            snap_x_q       <= '0;
            snap_y_q       <= '0;
            snap_z_q       <= '0;
            snap_err_q     <= '0;
            acc_x_q        <= '0;
            acc_y_q        <= '0;
            acc_z_q        <= '0;
            acc_error_q    <= '0;
            err_sat_q      <= 1'b0;
            missing_mask_q <= '0;
            busy_q         <= 1'b0;
            plugin_start_q <= 1'b0;
            out_valid_q    <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            snap_valid_q   <= snap_valid_d;
            snap_x_q       <= snap_x_d;
            snap_y_q       <= snap_y_d;
            snap_z_q       <= snap_z_d;
            snap_err_q     <= snap_err_d;
            acc_x_q        <= acc_x_d;
            acc_y_q        <= acc_y_d;
            acc_z_q        <= acc_z_d;
            acc_error_q    <= acc_error_d;
            err_sat_q      <= err_sat_d;
            missing_mask_q <= missing_mask_d;
            busy_q         <= busy_d;
            plugin_start_q <= plugin_start_d;
            out_valid_q    <= out_valid_d;
        end
    end

    assign busy         = busy_q;
    assign plugin_start = plugin_start_q;
    assign out_valid    = out_valid_q;
    assign acc_x        = acc_x_q;
    assign acc_y        = acc_y_q;
    assign acc_z        = acc_z_q;
    assign acc_error    = acc_error_q;
    assign err_sat      = err_sat_q;
    assign missing_mask = missing_mask_q;

endmodule

// File: tb/tb_plugin_collector.sv
// Randomized scoreboard bench for plugin_collector: a stimulus process issues rounds and
// queues expected sums; a monitor pops and compares on every result handshake.
module tb_plugin_collector;
    localparam int N  = 3;
    localparam int WW = 16;
    localparam int EW = 32;
    localparam int AW = 20;
    localparam int CC = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              req;
    logic              busy;
    logic              plugin_start;
    logic [N-1:0]      plugin_valid_bus;
    logic [N*WW-1:0]   plugin_warp_x_bus;
    logic [N*WW-1:0]   plugin_warp_y_bus;
    logic [N*WW-1:0]   plugin_warp_z_bus;
    logic [N*EW-1:0]   plugin_error_bus;
    logic              out_valid;
    logic              out_ready;
    logic [AW-1:0]     acc_x;
    logic [AW-1:0]     acc_y;
    logic [AW-1:0]     acc_z;
    logic [EW-1:0]     acc_error;
    logic              err_sat;
    logic [N-1:0]      missing_mask;

    plugin_collector #(
        .NUM_PLUGINS(N), .WARP_WIDTH(WW), .ERROR_WIDTH(EW),
        .ACC_WIDTH(AW), .COLLECT_CYCLES(CC)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .busy(busy), .plugin_start(plugin_start),
        .plugin_valid_bus(plugin_valid_bus),
        .plugin_warp_x_bus(plugin_warp_x_bus), .plugin_warp_y_bus(plugin_warp_y_bus),
        .plugin_warp_z_bus(plugin_warp_z_bus), .plugin_error_bus(plugin_error_bus),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_x(acc_x), .acc_y(acc_y), .acc_z(acc_z), .acc_error(acc_error),
        .err_sat(err_sat), .missing_mask(missing_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] x, y, z;
        logic [EW-1:0] e;
        logic          s;
        logic [N-1:0]  m;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad   = 0;

    // Values the plugins present at the snapshot cycle of the next round.
    logic [N-1:0]  sv;
    logic [WW-1:0] sx[N], sy[N], sz[N];
    logic [EW-1:0] se[N];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // snap=1 drives the snapshot values, otherwise random junk that must be ignored.
    task automatic drive_bus(input logic [N-1:0] v, input bit snap);
        plugin_valid_bus = v;
        for (int i = 0; i < N; i++) begin
            plugin_warp_x_bus[i*WW +: WW] = snap ? sx[i] : WW'($urandom);
            plugin_warp_y_bus[i*WW +: WW] = snap ? sy[i] : WW'($urandom);
            plugin_warp_z_bus[i*WW +: WW] = snap ? sz[i] : WW'($urandom);
            plugin_error_bus[i*EW +: EW]  = snap ? se[i] : EW'($urandom);
        end
    endtask

    function automatic exp_t model();
        exp_t   r;
        longint tx = 0, ty = 0, tz = 0, te = 0;
        longint emax = (longint'(1) << EW) - 1;
        for (int i = 0; i < N; i++) begin
            if (sv[i]) begin
                tx += longint'($signed(sx[i]));
                ty += longint'($signed(sy[i]));
                tz += longint'($signed(sz[i]));
                te += longint'(se[i]);
            end
        end
        r.x = tx[AW-1:0];
        r.y = ty[AW-1:0];
        r.z = tz[AW-1:0];
        r.s = (te > emax);
        r.e = r.s ? {EW{1'b1}} : te[EW-1:0];
        r.m = ~sv;
        return r;
    endfunction

    task automatic rand_snap(input bit big_err);
        sv = N'($urandom);
        for (int i = 0; i < N; i++) begin
            sx[i] = WW'($urandom);
            sy[i] = WW'($urandom);
            sz[i] = WW'($urandom);
            se[i] = big_err ? (EW'($urandom) | 32'hC000_0000) : EW'($urandom_range(0, 1000));
        end
    endtask

    task automatic run_round(input int stall, input bit grand, input logic [N-1:0] gv);
        logic [AW-1:0] hx, hy, hz;
        logic [EW-1:0] he;
        logic [N-1:0]  hm;
        logic          hs;
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        chk("start_pulse", 64'(plugin_start), 64'd1);
        chk("busy_start", 64'(busy), 64'd1);
        for (int c = 2; c <= CC + 1; c++) begin
            @(posedge clk); #1;
            chk("start_low", 64'(plugin_start), 64'd0);
            if (c == CC + 1) begin
                drive_bus(sv, 1'b1);
                sbq.push_back(model());
            end else begin
                drive_bus(grand ? N'($urandom) : gv, 1'b0);
            end
        end
        for (int k = 0; k < N; k++) begin
            @(posedge clk); #1;
            chk("no_early_valid", 64'(out_valid), 64'd0);
            drive_bus(N'($urandom), 1'b0);
        end
        @(posedge clk); #1;
        chk("valid_latency", 64'(out_valid), 64'd1);
        hx = acc_x; hy = acc_y; hz = acc_z; he = acc_error; hm = missing_mask; hs = err_sat;
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            req = (s == 0) ? 1'b1 : 1'($urandom);
            @(posedge clk); #1;
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_no_start", 64'(plugin_start), 64'd0);
            chk("stall_hold", {acc_x, acc_y, acc_z}, {4'd0, hx, hy, hz});
            chk("stall_hold_err", {hs, hm, acc_error}, {err_sat, missing_mask, he});
        end
        req = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        out_ready = 1'b0;
        chk("done_exit_valid", 64'(out_valid), 64'd0);
        chk("done_exit_busy", 64'(busy), 64'd0);
        chk("done_exit_no_start", 64'(plugin_start), 64'd0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {busy, plugin_start, out_valid, err_sat, missing_mask, acc_x, acc_y, acc_z},
            64'd0);
        chk({nm, "_err"}, 64'(acc_error), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_result", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("acc_x", 64'(acc_x), 64'(e.x));
                chk("acc_y", 64'(acc_y), 64'(e.y));
                chk("acc_z", 64'(acc_z), 64'(e.z));
                chk("acc_error", 64'(acc_error), 64'(e.e));
                chk("err_sat", 64'(err_sat), 64'(e.s));
                chk("missing_mask", 64'(missing_mask), 64'(e.m));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 1'b0; out_ready = 1'b0;
        plugin_valid_bus = '0;
        plugin_warp_x_bus = '0; plugin_warp_y_bus = '0; plugin_warp_z_bus = '0;
        plugin_error_bus = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset_state");
        rst = 1'b0;
        @(posedge clk); #1;

        // All valid: x = 1 + 2 - 1, errors 1+2+3.
        sv = 3'b111;
        sx[0] = 16'h0001; sx[1] = 16'h0002; sx[2] = 16'hFFFF;
        sy[0] = 16'h0000; sy[1] = 16'h0000; sy[2] = 16'h0000;
        sz[0] = 16'h1234; sz[1] = 16'h8000; sz[2] = 16'h7FFF;
        se[0] = 32'd1; se[1] = 32'd2; se[2] = 32'd3;
        run_round(0, 1'b0, 3'b111);

        // Plugin 1 missing; y = 0x0010 + sext(0x8000).
        sv = 3'b101;
        sy[0] = 16'h0010; sy[1] = 16'h7FFF; sy[2] = 16'h8000;
        run_round(0, 1'b0, 3'b111);

        // Error saturation.
        sv = 3'b111;
        se[0] = 32'hFFFF_FFFF; se[1] = 32'h2; se[2] = 32'h0;
        run_round(1, 1'b1, 3'b000);

        // Plugin 2 valid through the window but dropped at the snapshot.
        sv = 3'b011;
        se[0] = 32'd10; se[1] = 32'd20; se[2] = 32'd30;
        sx[2] = 16'h4000; sy[2] = 16'h4000; sz[2] = 16'h4000;
        run_round(0, 1'b0, 3'b111);

        // Long stall in DONE with req pulses.
        rand_snap(1'b0);
        run_round(5, 1'b1, 3'b000);
        chk("idle_after_stall_start", 64'(plugin_start), 64'd0);

        // Reset in the third COLLECT cycle abandons the round.
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        drive_bus(3'b111, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_all_zero("mid_round_reset");
        repeat (CC + N + 3) begin
            @(posedge clk); #1;
            chk("after_reset_idle", {busy, plugin_start, out_valid}, 64'd0);
        end
        rand_snap(1'b0);
        sv = 3'b110;
        run_round(0, 1'b1, 3'b000);

        for (int r = 0; r < 30; r++) begin
            rand_snap(r % 3 == 0);
            run_round($urandom_range(0, 3), 1'b1, 3'b000);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
